chan_fsm_array: RTL and testbench
=================================

# chan_fsm_array

Parametrised array of NCHAN identical per-channel state machines sharing one serialised resource through a round-robin arbiter. Each channel walks IDLE → REQ → BUSY → DONE → IDLE with a programmable busy length. Per-channel state is exported as an enum-typed packed array so waveform dumps show symbolic state names for every channel. The block is the multi-channel successor to the single-enum state-tracing testbench and is used as the standard enum/array trace fixture.

## Interface
- NCHAN, 4, number of channels (2..16)
- CNT_W, 8, width of the per-channel busy-length field
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  NCHAN  per-channel start request, sampled only in IDLE
- len_i  in  NCHAN*CNT_W  busy length for channel k in bits [k*CNT_W +: CNT_W], latched with start
- done_ack_i  in  NCHAN  per-channel acknowledge, consumed only in DONE
- state_o  out  NCHAN×state_t  current state of each channel (packed array of enum)
- grant_o  out  NCHAN  one-hot or zero; combinational grant this cycle
- done_o  out  NCHAN  high while channel is in DONE
- busy_o  out  1  high while any channel is in BUSY
- active_o  out  $clog2(NCHAN+1)  count of channels not in IDLE

## Operation
- Reset: all channels IDLE, counters 0, arbiter pointer 0, all outputs 0.
- IDLE: start_i[k]=1 → REQ at next edge; len_i slice latched into len_q[k]. Otherwise stay.
- REQ: wait for grant. Resource free when no channel is BUSY. When free, arbiter picks the first REQ channel at or after pointer (wrapping mod NCHAN); grant_o one-hot for that channel.
- On the granting edge: if len_q≠0 → BUSY with cnt=len_q−1; if len_q=0 → DONE directly (zero busy cycles). Pointer ← granted index+1 mod NCHAN.
- BUSY: cnt decrements each cycle; at cnt=0 → DONE at next edge. Channel is BUSY for exactly len_q cycles.
- DONE: done_o[k]=1; done_ack_i[k]=1 → IDLE at next edge. start_i ignored outside IDLE; done_ack_i ignored outside DONE.
- At most one channel BUSY at any time (invariant, checked by assertion).
- Width rule: cnt is CNT_W bits, no wrap; len_q max 2^CNT_W−1.

## Timing
- start at edge t → REQ visible after t; earliest grant same cycle (combinational) → BUSY after t+1.
- Back-to-back: BUSY→DONE edge frees resource; next grant asserted in the following cycle (one-cycle gap between BUSY periods).
- Simultaneous REQ: lowest index at/after pointer wins; others hold REQ.
- done_ack and start on same channel in DONE: ack honoured, start ignored; new start must arrive in IDLE.
- Async reset mid-BUSY: immediately all IDLE, grant_o/done_o/busy_o low without waiting for a clock.
- active_o reflects registered state (same cycle as state_o).

## Structure
- Package chan_fsm_pkg: typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BUSY, ST_DONE} state_t; no other contents.
- Sub-module rr_arbiter (parameter N): inputs req[N], en, outputs one-hot gnt[N]; owns pointer register, updates it only when a grant is issued.
- Per-channel FSM and counter in a generate loop in the top.

## Test plan
- Reset: assert rst_n=0 mid-run with ch1 BUSY → all state_o=ST_IDLE, busy_o=0, active_o=0 immediately.
- Single channel: ch0 start, len=3 → grant_o=0001 one cycle, BUSY exactly 3 cycles, done_o[0]=1 until ack, then IDLE.
- Zero length: ch2 start, len=0 → REQ→DONE on grant edge, busy_o never high.
- Contention: ch0..ch3 start same cycle, len=2 each → grants in order 0,1,2,3, each BUSY 2 cycles, one-cycle gap between, never two BUSY.
- Fairness wrap: pointer at 3, REQ on ch1 and ch3 → ch3 granted first, then ch1.
- Ignored inputs: start during BUSY and done_ack during REQ → no state change; active_o counts unchanged.

Source files
------------

// File: rtl/chan_fsm_pkg.sv
// -----------------------------------------------------------------------------
// chan_fsm_pkg
//   Shared types for the multi-channel state-machine array.
//   state_t : per-channel lifecycle IDLE -> REQ -> BUSY -> DONE -> IDLE.
//   It is exported on the top-level ports as a packed array, so waveform
//   viewers show the symbolic state of every channel.
// -----------------------------------------------------------------------------
package chan_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : chan_fsm_pkg

// File: rtl/chan_fsm_array_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter for N requesters sharing one resource.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (pointer returns to 0)
//     req   : per-requester request vector
//     en    : resource free this cycle; no grant is issued while low
//     gnt   : combinational one-hot grant, or all zero
//   The search starts at the pointer and wraps modulo N, so the first
//   requester at or after the pointer wins. The pointer moves to the slot
//   just after the winner, and only when a grant is actually issued.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Rotating priority search: candidate i is (ptr + i) mod N.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % N);
            if (!found && en && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Advance past the winner only when something was granted.
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples pre-edge values, independent of
            // process ordering.
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter

// File: rtl/chan_fsm_array.sv
// -----------------------------------------------------------------------------
// chan_fsm_array
//   NCHAN identical channel state machines sharing one serialised resource.
//   Each channel walks IDLE -> REQ -> BUSY -> DONE -> IDLE. A channel in BUSY
//   owns the resource for exactly len cycles; a round-robin arbiter hands the
//   resource to REQ channels only when no channel is BUSY.
//
//   Parameters:
//     NCHAN : number of channels (2..16)
//     CNT_W : width of the per-channel busy-length field
//   Ports:
//     clk        : rising-edge clock
//     rst_n      : asynchronous active-low reset
//     start_i    : per-channel start, sampled only in IDLE
//     len_i      : busy length, channel k in [k*CNT_W +: CNT_W], latched
//                  together with start
//     done_ack_i : per-channel acknowledge, consumed only in DONE
//     state_o    : registered state of every channel (packed enum array)
//     grant_o    : combinational one-hot grant (or zero) this cycle
//     done_o     : high while the channel is in DONE
//     busy_o     : high while any channel is in BUSY
//     active_o   : number of channels not in IDLE
//
//   Every output is decoded from registered state, so an asynchronous reset
//   clears all of them immediately without waiting for a clock.
// -----------------------------------------------------------------------------
module chan_fsm_array
    import chan_fsm_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NCHAN-1:0]             start_i,
    input  logic [NCHAN*CNT_W-1:0]       len_i,
    input  logic [NCHAN-1:0]             done_ack_i,
    output state_t [NCHAN-1:0]           state_o,
    output logic [NCHAN-1:0]             grant_o,
    output logic [NCHAN-1:0]             done_o,
    output logic                         busy_o,
    output logic [$clog2(NCHAN+1)-1:0]   active_o
);

    localparam int ACT_W = $clog2(NCHAN + 1);

    logic [NCHAN-1:0] req_vec;
    logic [NCHAN-1:0] busy_vec;
    logic             res_free;

    // The resource is free only when nobody is BUSY. A channel leaving BUSY
    // on an edge frees it for the following cycle, which gives the
    // one-cycle gap between consecutive BUSY periods.
    assign res_free = ~|busy_vec;

    rr_arbiter #(
        .N (NCHAN)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_vec),
        .en    (res_free),
        .gnt   (grant_o)
    );

    // -------------------------------------------------------------------------
    // Per-channel FSM and busy counter
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < NCHAN; k++) begin : g_chan
        state_t           st_q;
        state_t           st_d;
        logic [CNT_W-1:0] len_q;
        logic [CNT_W-1:0] cnt_q;
        logic             req_k;
        logic             busy_k;
        logic             done_k;

        // State register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q <= ST_IDLE;
            end else begin
                st_q <= st_d;
            end
        end

        // Next-state logic. start is only looked at in IDLE and done_ack only
        // in DONE, so either input is ignored everywhere else.
        always_comb begin
            st_d = st_q;
            case (st_q)
                ST_IDLE: if (start_i[k])    st_d = ST_REQ;
                ST_REQ:  if (grant_o[k])    st_d = (len_q != '0) ? ST_BUSY : ST_DONE;
                ST_BUSY: if (cnt_q == '0)   st_d = ST_DONE;
                ST_DONE: if (done_ack_i[k]) st_d = ST_IDLE;
                default:                    st_d = ST_IDLE;
            endcase
        end

        // Output decode.
        always_comb begin
            req_k  = (st_q == ST_REQ);
            busy_k = (st_q == ST_BUSY);
            done_k = (st_q == ST_DONE);
        end

        assign state_o[k]  = st_q;
        assign req_vec[k]  = req_k;
        assign busy_vec[k] = busy_k;
        assign done_o[k]   = done_k;

        // Length latch and busy counter. The counter is loaded with len-1 on
        // the granting edge, so the channel stays BUSY for exactly len
        // cycles (it leaves BUSY on the edge where cnt is already 0).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                len_q <= '0;
                cnt_q <= '0;
            end else begin
                if (st_q == ST_IDLE && start_i[k]) begin
                    len_q <= len_i[k*CNT_W +: CNT_W];
                end
                if (st_q == ST_REQ && grant_o[k] && len_q != '0) begin
                    cnt_q <= len_q - CNT_W'(1);
                end else if (st_q == ST_BUSY && cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end : g_chan

    // -------------------------------------------------------------------------
    // Aggregate status
    // -------------------------------------------------------------------------
    assign busy_o = |busy_vec;

    always_comb begin
        active_o = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (state_o[i] != ST_IDLE) begin
                active_o = active_o + ACT_W'(1);
            end
        end
    end

    // The shared resource is never owned by more than one channel.
    a_single_busy : assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(busy_vec)
    );

endmodule : chan_fsm_array

// File: tb/tb_chan_fsm_array.sv
// -----------------------------------------------------------------------------
// tb_chan_fsm_array
//   Directed bench for chan_fsm_array with NCHAN=4, CNT_W=8. Each table row
//   holds the inputs applied for one clock edge and the outputs expected just
//   after that edge. Reset behaviour (initial and asynchronous mid-BUSY) is
//   exercised by hand-written sequences around the table.
// -----------------------------------------------------------------------------
module tb_chan_fsm_array;
    import chan_fsm_pkg::*;

    localparam int NCHAN = 4;
    localparam int CNT_W = 8;

    localparam logic [1:0] SI = 2'd0;
    localparam logic [1:0] SR = 2'd1;
    localparam logic [1:0] SB = 2'd2;
    localparam logic [1:0] SD = 2'd3;

    logic                      clk;
    logic                      rst_n;
    logic [NCHAN-1:0]          start_i;
    logic [NCHAN*CNT_W-1:0]    len_i;
    logic [NCHAN-1:0]          done_ack_i;
    state_t [NCHAN-1:0]        state_o;
    logic [NCHAN-1:0]          grant_o;
    logic [NCHAN-1:0]          done_o;
    logic                      busy_o;
    logic [2:0]                active_o;

    logic [2*NCHAN-1:0]        st_flat;
    assign st_flat = state_o;

    chan_fsm_array #(
        .NCHAN (NCHAN),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .len_i      (len_i),
        .done_ack_i (done_ack_i),
        .state_o    (state_o),
        .grant_o    (grant_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .active_o   (active_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] st, input logic [3:0] g,
                             input logic [3:0] d, input logic b, input logic [2:0] ac);
        check({tag, " state"},  32'(st_flat),  32'(st));
        check({tag, " grant"},  32'(grant_o),  32'(g));
        check({tag, " done"},   32'(done_o),   32'(d));
        check({tag, " busy"},   32'(busy_o),   32'(b));
        check({tag, " active"}, 32'(active_o), 32'(ac));
    endtask

    // Outputs are examined 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [3:0]  start;
        logic [31:0] len;
        logic [3:0]  ack;
        logic [7:0]  st;     // {ch3, ch2, ch1, ch0}
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic        busy;
        logic [2:0]  act;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] s, input logic [31:0] l, input logic [3:0] a,
                                input logic [7:0] st, input logic [3:0] g, input logic [3:0] d,
                                input logic b, input logic [2:0] ac);
        vec_t v;
        v.start = s; v.len = l; v.ack = a;
        v.st = st; v.gnt = g; v.done = d; v.busy = b; v.act = ac;
        return v;
    endfunction

    initial begin
        // ---- Contention: all four start together, len=2, pointer at 0 ----
        vecs.push_back(mk(4'hF, 32'h02020202, 4'h0, {SR,SR,SR,SR}, 4'h1, 4'h0, 1'b0, 3'd4));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SR,SR,SR,SB}, 4'h0, 4'h0, 1'b1, 3'd4));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SR,SR,SR,SB}, 4'h0, 4'h0, 1'b1, 3'd4));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SR,SR,SR,SD}, 4'h2, 4'h1, 1'b0, 3'd4));
        vecs.push_back(mk(4'h0, 32'h0,        4'h1, {SR,SR,SB,SI}, 4'h0, 4'h0, 1'b1, 3'd3));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SR,SR,SB,SI}, 4'h0, 4'h0, 1'b1, 3'd3));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SR,SR,SD,SI}, 4'h4, 4'h2, 1'b0, 3'd3));
        vecs.push_back(mk(4'h0, 32'h0,        4'h2, {SR,SB,SI,SI}, 4'h0, 4'h0, 1'b1, 3'd2));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SR,SB,SI,SI}, 4'h0, 4'h0, 1'b1, 3'd2));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SR,SD,SI,SI}, 4'h8, 4'h4, 1'b0, 3'd2));
        vecs.push_back(mk(4'h0, 32'h0,        4'h4, {SB,SI,SI,SI}, 4'h0, 4'h0, 1'b1, 3'd1));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SB,SI,SI,SI}, 4'h0, 4'h0, 1'b1, 3'd1));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SD,SI,SI,SI}, 4'h0, 4'h8, 1'b0, 3'd1));
        vecs.push_back(mk(4'h0, 32'h0,        4'h8, {SI,SI,SI,SI}, 4'h0, 4'h0, 1'b0, 3'd0));
        // ---- Single channel: ch0, len=3, pointer at 0 ----
        vecs.push_back(mk(4'h1, 32'h00000003, 4'h0, {SI,SI,SI,SR}, 4'h1, 4'h0, 1'b0, 3'd1));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SI,SI,SI,SB}, 4'h0, 4'h0, 1'b1, 3'd1));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SI,SI,SI,SB}, 4'h0, 4'h0, 1'b1, 3'd1));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SI,SI,SI,SB}, 4'h0, 4'h0, 1'b1, 3'd1));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SI,SI,SI,SD}, 4'h0, 4'h1, 1'b0, 3'd1));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SI,SI,SI,SD}, 4'h0, 4'h1, 1'b0, 3'd1));
        vecs.push_back(mk(4'h0, 32'h0,        4'h1, {SI,SI,SI,SI}, 4'h0, 4'h0, 1'b0, 3'd0));
        // ---- Zero length: ch2, len=0, pointer at 1; then ack+start in DONE ----
        vecs.push_back(mk(4'h4, 32'h0,        4'h0, {SI,SR,SI,SI}, 4'h4, 4'h0, 1'b0, 3'd1));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SI,SD,SI,SI}, 4'h0, 4'h4, 1'b0, 3'd1));
        vecs.push_back(mk(4'h4, 32'h0,        4'h4, {SI,SI,SI,SI}, 4'h0, 4'h0, 1'b0, 3'd0));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SI,SI,SI,SI}, 4'h0, 4'h0, 1'b0, 3'd0));
        // ---- Fairness wrap: pointer at 3, ch1 and ch3 request, len=2 ----
        vecs.push_back(mk(4'hA, 32'h02020202, 4'h0, {SR,SI,SR,SI}, 4'h8, 4'h0, 1'b0, 3'd2));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SB,SI,SR,SI}, 4'h0, 4'h0, 1'b1, 3'd2));
        // start on BUSY ch3, ack on REQ ch1: both ignored
        vecs.push_back(mk(4'h8, 32'h0,        4'h2, {SB,SI,SR,SI}, 4'h0, 4'h0, 1'b1, 3'd2));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SD,SI,SR,SI}, 4'h2, 4'h8, 1'b0, 3'd2));
        vecs.push_back(mk(4'h0, 32'h0,        4'h8, {SI,SI,SB,SI}, 4'h0, 4'h0, 1'b1, 3'd1));
        vecs.push_back(mk(4'h0, 32'h0,        4'h0, {SI,SI,SB,SI}, 4'h0, 4'h0, 1'b1, 3'd1));
    end

    initial begin
        rst_n      = 1'b0;
        start_i    = '0;
        len_i      = '0;
        done_ack_i = '0;

        // ---- Reset state ----
        #12;
        check_all("reset", {SI,SI,SI,SI}, 4'h0, 4'h0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all("post_reset", {SI,SI,SI,SI}, 4'h0, 4'h0, 1'b0, 3'd0);

        // ---- Table-driven vectors ----
        for (int i = 0; i < vecs.size(); i++) begin
            start_i    = vecs[i].start;
            len_i      = vecs[i].len;
            done_ack_i = vecs[i].ack;
            tick();
            check_all($sformatf("row%0d", i), vecs[i].st, vecs[i].gnt, vecs[i].done,
                      vecs[i].busy, vecs[i].act);
        end
        start_i    = '0;
        len_i      = '0;
        done_ack_i = '0;

        // ---- Asynchronous reset while ch1 is BUSY (no clock edge involved) ----
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", {SI,SI,SI,SI}, 4'h0, 4'h0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Pointer returned to 0 by reset: ch0 beats ch3 ----
        start_i = 4'h9;
        len_i   = 32'h01000001;
        tick();
        start_i = '0;
        check_all("ptr_reset", {SR,SI,SI,SR}, 4'h1, 4'h0, 1'b0, 3'd2);
        tick();
        check_all("ptr_reset_busy", {SR,SI,SI,SB}, 4'h0, 4'h0, 1'b1, 3'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_chan_fsm_array
